// File: rtl/avst_packet_arbiter.sv
// Packet-level round-robin arbiter for NUM_INPUTS Avalon-ST sources; grant held SOP..accepted EOP.
// Optional per-source packet counters are enabled by defining AVST_ARB_STATS_EN.
module avst_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = $clog2(NUM_INPUTS),
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] in_valid_i,
    input  logic [NUM_INPUTS-1:0] in_sop_i,
    input  logic [NUM_INPUTS-1:0] in_eop_i,
    output logic [NUM_INPUTS-1:0] in_ready_o,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [NUM_INPUTS-1:0] grant_o,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  busy_o,
    output logic                  sop_err_o
`ifdef AVST_ARB_STATS_EN
    ,
    input  logic [SEL_W-1:0]      stat_sel_i,
    output logic [STAT_W-1:0]     stat_pkts_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [NUM_INPUTS-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic                    firstBeat_q, firstBeat_d;
    logic                    sopErr_q, sopErr_d;

    logic [NUM_INPUTS-1:0]   req;
    logic                    anyReq;
    logic                    locked;
    logic                    accept;
    logic                    eopAccept;
    logic                    load;
    logic                    found;
    logic [SEL_W-1:0]        winIdx;

    assign req       = in_valid_i & in_sop_i;
    assign anyReq    = |req;
    assign locked    = (state_q == LOCKED);

    assign out_valid_o = locked & |(in_valid_i & grant_q);
    assign in_ready_o  = locked ? (grant_q & {NUM_INPUTS{out_ready_i}}) : '0;
    assign accept      = out_valid_o & out_ready_i;
    assign eopAccept   = accept & in_eop_i[sel_q];

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = locked;
    assign sop_err_o = sopErr_q;

    // Search starts just after the last winner, so the previous owner ranks last.
    always_comb begin
        found  = 1'b0;
        winIdx = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NUM_INPUTS]) begin
                found  = 1'b1;
                winIdx = SEL_W'((int'(ptr_q) + k) % NUM_INPUTS);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        firstBeat_d = firstBeat_q;
        sopErr_d    = sopErr_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyReq) load = 1'b1;
            end
            LOCKED: begin
                if (accept && firstBeat_q) begin
                    firstBeat_d = 1'b0;
                    if (!in_sop_i[sel_q]) sopErr_d = 1'b1;
                end
                if (eopAccept) begin
                    if (anyReq) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh grant re-arms the first-beat SOP check, overriding the release above.
        if (load) begin
            state_d     = LOCKED;
            grant_d     = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << winIdx;
            sel_d       = winIdx;
            ptr_d       = winIdx;
            firstBeat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            ptr_q       <= SEL_W'(NUM_INPUTS - 1);
            firstBeat_q <= 1'b0;
            sopErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            firstBeat_q <= firstBeat_d;
            sopErr_q    <= sopErr_d;
        end
    end

`ifdef AVST_ARB_STATS_EN
    logic [STAT_W-1:0] statCnt_q [NUM_INPUTS];
    logic [STAT_W-1:0] statPkts_q;

    // Counters saturate at all-ones; readback is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) statCnt_q[i] <= '0;
            statPkts_q <= '0;
        end else begin
            if (eopAccept && (statCnt_q[sel_q] != '1))
                statCnt_q[sel_q] <= statCnt_q[sel_q] + STAT_W'(1);
            statPkts_q <= statCnt_q[stat_sel_i];
        end
    end

    assign stat_pkts_o = statPkts_q;
`endif

endmodule

// File: tb/tb_avst_packet_arbiter.sv
// Self-checking bench for avst_packet_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin packet model.
module tb_avst_packet_arbiter;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int STW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  inValid = '0;
    logic [N-1:0]  inSop = '0;
    logic [N-1:0]  inEop = '0;
    logic [N-1:0]  inReady;
    logic          outReady = 1'b0;
    logic          outValid;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          busy;
    logic          sopErr;
`ifdef AVST_ARB_STATS_EN
    logic [SW-1:0]  statSel = '0;
    logic [STW-1:0] statPkts;
`endif

    int tests = 0;
    int failCount = 0;

    // Behavioural model: owner is the granted source or -1 when idle.
    int owner;
    int lastWinner;
    bit firstPending;
    bit sopErrExp;
    int pktCount [N];
    int accSrc;

    // Traffic generator state per source.
    int rem [N];
    bit first [N];

    always #5 clk = ~clk;

    avst_packet_arbiter #(
        .NUM_INPUTS(N),
        .STAT_W    (STW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid_i (inValid),
        .in_sop_i   (inSop),
        .in_eop_i   (inEop),
        .in_ready_o (inReady),
        .out_ready_i(outReady),
        .out_valid_o(outValid),
        .grant_o    (grant),
        .sel_o      (sel),
        .busy_o     (busy),
        .sop_err_o  (sopErr)
`ifdef AVST_ARB_STATS_EN
        ,
        .stat_sel_i (statSel),
        .stat_pkts_o(statPkts)
`endif
    );

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        owner        = -1;
        lastWinner   = N - 1;
        firstPending = 1'b0;
        sopErrExp    = 1'b0;
        accSrc       = -1;
        for (int i = 0; i < N; i++) begin
            pktCount[i] = 0;
            rem[i]      = 0;
            first[i]    = 1'b0;
        end
    endtask

    // Round robin: first requester found walking upward from the source after the last winner.
    function automatic int pickNext(input logic [N-1:0] req);
        for (int off = 1; off <= N; off++) begin
            if (req[(lastWinner + off) % N]) return (lastWinner + off) % N;
        end
        return -1;
    endfunction

    task automatic modelGrant(input logic [N-1:0] req);
        owner        = pickNext(req);
        lastWinner   = owner;
        firstPending = 1'b1;
    endtask

    task automatic modelStep(input logic [N-1:0] v, input logic [N-1:0] s,
                             input logic [N-1:0] e, input logic r);
        logic [N-1:0] req;
        req    = v & s;
        accSrc = -1;
        if (owner < 0) begin
            if (req != '0) modelGrant(req);
        end else if (v[owner] && r) begin
            accSrc = owner;
            if (firstPending) begin
                if (!s[owner]) sopErrExp = 1'b1;
                firstPending = 1'b0;
            end
            if (e[owner]) begin
                if (pktCount[owner] < (1 << STW) - 1) pktCount[owner]++;
                if (req != '0) modelGrant(req);
                else owner = -1;
            end
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] expGrant;
        expGrant = '0;
        if (owner >= 0) expGrant[owner] = 1'b1;
        compare("grant", 32'(grant), 32'(expGrant));
        compare("busy", 32'(busy), 32'(owner >= 0));
        compare("sop_err", 32'(sopErr), 32'(sopErrExp));
        compare("in_ready", 32'(inReady), 32'((owner >= 0 && outReady) ? expGrant : '0));
        compare("out_valid", 32'(outValid), 32'(owner >= 0 && inValid[owner]));
        if (owner >= 0) compare("sel", 32'(sel), 32'(owner));
    endtask

    // Drive one cycle of inputs, check mid-cycle, advance the model across the edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] s,
                                 input logic [N-1:0] e, input logic r);
        inValid  = v;
        inSop    = s;
        inEop    = e;
        outReady = r;
        @(negedge clk);
        checkOutput();
        modelStep(v, s, e, r);
        @(posedge clk);
        #1;
    endtask

    task automatic genCycle(input int startPct, input int bubblePct, input int readyPct,
                            input int minLen, input int maxLen);
        logic [N-1:0] v, s, e;
        logic r;
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && int'($urandom_range(99)) < startPct) begin
                rem[i]   = int'($urandom_range(maxLen, minLen));
                first[i] = 1'b1;
            end
            v[i] = (rem[i] > 0) && (first[i] || int'($urandom_range(99)) >= bubblePct);
            s[i] = first[i];
            e[i] = (rem[i] == 1);
        end
        r = int'($urandom_range(99)) < readyPct;
        applyStimulus(v, s, e, r);
        if (accSrc >= 0) begin
            rem[accSrc]--;
            first[accSrc] = 1'b0;
        end
    endtask

    function automatic bit allIdle();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
        return owner < 0;
    endfunction

    task automatic drain();
        for (int k = 0; k < 80 && !allIdle(); k++) genCycle(0, 0, 100, 2, 2);
        compare("drain_done", 32'(busy), 32'(0));
    endtask

    task automatic doReset();
        inValid  = '0;
        inSop    = '0;
        inEop    = '0;
        outReady = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        // Single 3-beat packet on source 0.
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
        compare("t1_grant_load", 32'(grant), 32'(4'b0001));
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b1);
        compare("t1_release_grant", 32'(grant), 32'(0));
        compare("t1_release_busy", 32'(busy), 32'(0));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // All sources continuously requesting 2-beat packets: order 0,1,2,3,0 without gaps.
        doReset();
        for (int c = 0; c < 10; c++) begin
            genCycle(100, 0, 100, 2, 2);
            if (c % 2 == 0) begin
                compare("t2_rr_order", 32'(sel), 32'((c / 2) % N));
                compare("t2_no_idle", 32'(busy), 32'(1));
            end
        end
        drain();

        // Source 1 with EOP held while out_ready is low.
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b0);
        compare("t3_hold_on_stall", 32'(grant), 32'(4'b0010));
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b0);
        compare("t3_hold_on_stall2", 32'(grant), 32'(4'b0010));
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1);
        compare("t3_release", 32'(grant), 32'(0));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Source 0 requests while source 2 is mid-packet; handed over back-to-back.
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1);
        applyStimulus(4'b0101, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(4'b0101, 4'b0001, 4'b0100, 1'b1);
        compare("t4_handover", 32'(grant), 32'(4'b0001));
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Granted source whose first accepted beat lacks SOP.
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b1);
        compare("t5_sop_err_set", 32'(sopErr), 32'(1));
        applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        compare("t5_sop_err_sticky", 32'(sopErr), 32'(1));
        compare("t5_released", 32'(grant), 32'(0));

        // Reset asserted mid-packet clears the handshake immediately.
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1);
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1);
        inValid  = 4'b1000;
        inSop    = 4'b0000;
        outReady = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        compare("rst_grant", 32'(grant), 32'(0));
        compare("rst_in_ready", 32'(inReady), 32'(0));
        compare("rst_out_valid", 32'(outValid), 32'(0));
        compare("rst_sop_err", 32'(sopErr), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();

        // Randomized traffic with bubbles and backpressure.
        for (int c = 0; c < 1500; c++) genCycle(30, 20, 75, 2, 4);
        drain();

`ifdef AVST_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            statSel = SW'(i);
            repeat (2) @(posedge clk);
            #1;
            compare("stat_pkts", 32'(statPkts), 32'(pktCount[i]));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failCount);
        $finish;
    end

endmodule

// File: doc/avst_packet_arbiter.md
# avst_packet_arbiter

Packet-level round-robin arbiter that shares one Avalon-ST output among NUM_INPUTS Avalon-ST sources. Grants are locked from SOP to the accepted EOP, so packets from different sources never interleave. The block drives per-input ready and a select index; the payload multiplexer (channel/data/empty) is external and keyed on `sel`. It sits in front of the stream multiplexer datapath and replaces its hard-wired two-way priority.

## Interface
- NUM_INPUTS, 4, number of requesting sources (2..8)
- SEL_W, $clog2(NUM_INPUTS), width of `sel`
- STAT_W, 16, width of per-input statistics counters (used only with AVST_ARB_STATS_EN)

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_INPUTS  per-source valid
- in_sop  in  NUM_INPUTS  per-source start of packet
- in_eop  in  NUM_INPUTS  per-source end of packet
- in_ready  out  NUM_INPUTS  per-source ready, combinational
- out_ready  in  1  downstream ready
- out_valid  out  1  valid of the granted source, combinational
- grant  out  NUM_INPUTS  registered one-hot grant; all-zero when idle
- sel  out  SEL_W  registered binary index of the granted source
- busy  out  1  registered; 1 while in LOCKED
- sop_err  out  1  registered sticky flag; set when a granted source's first beat lacks SOP
- stat_sel  in  SEL_W  statistics read index (AVST_ARB_STATS_EN only)
- stat_pkts  out  STAT_W  completed-packet count of source `stat_sel` (AVST_ARB_STATS_EN only)

## Operation
- States: IDLE, LOCKED. Reset values: state IDLE, grant 0, sel 0, busy 0, sop_err 0, RR pointer NUM_INPUTS-1 (source 0 has first priority), stat counters 0.
- Request vector: req[i] = in_valid[i] & in_sop[i]. A valid beat without SOP on an ungranted source is not a request and is ignored.
- Arbitration: starting at pointer+1 mod NUM_INPUTS, pick the first set req bit, wrapping around. The winner is loaded into grant/sel, and the pointer is set to the winner.
- IDLE: if req != 0, arbitrate, go to LOCKED. Otherwise stay.
- LOCKED:
  - in_ready = grant & {NUM_INPUTS{out_ready}}.
  - out_valid = |(in_valid & grant).
  - Accepted beat = out_valid & out_ready.
  - Accepted beat with in_eop[sel]: release. If req != 0 in that same cycle, re-arbitrate and stay in LOCKED with the new grant. Otherwise go to IDLE with grant 0.
  - EOP on a non-accepted beat (out_ready=0) does not release.
  - Single-beat packet (SOP and EOP on the same beat) releases on acceptance.
- IDLE: in_ready = 0, out_valid = 0.
- sop_err: the first accepted beat after a grant is loaded must carry SOP. If it does not, sop_err is set and stays set until reset. The packet is still forwarded and released normally on EOP.
- Pointer update happens only on a grant load, never on release-to-IDLE.

## Timing
- Grant latency: req seen in IDLE at cycle k → grant/sel valid at k+1. The first beat can be accepted at k+1.
- Back-to-back: EOP accepted at cycle k with req pending → new grant at k+1, no idle cycle.
- A released source that presents a new SOP in the release cycle competes with lowest priority. If it is the only requester, it is re-granted at k+1.
- in_ready and out_valid respond combinationally to out_ready and in_valid within the cycle. There is no registered stage in the handshake path.
- Reset asserted mid-packet clears grant, in_ready, and out_valid immediately. The packet is truncated; upstream is responsible for flushing.

## Configuration
- AVST_ARB_STATS_EN defined: adds NUM_INPUTS saturating STAT_W-bit counters. Counter [sel] increments on each accepted EOP beat and holds at all-ones. stat_pkts = counter[stat_sel], registered (1-cycle read latency).
- AVST_ARB_STATS_EN undefined: no counters. The stat_sel and stat_pkts ports are omitted. All other behaviour is identical.

## Test plan
- Reset, then req = 4'b0001 with a 3-beat packet, out_ready=1 → grant=0001 one cycle later; in_ready[0] high for 3 beats; grant=0 the cycle after EOP; busy 1→0.
- All four sources assert SOP continuously with 2-beat packets → grant order 0,1,2,3,0, with no idle cycle between packets.
- Source 1 locked, out_ready toggles 1,0,1,0 during EOP → release only on the EOP beat where out_ready=1; grant stays 0010 before that.
- Source 2 mid-packet, source 0 asserts SOP → source 0 waits; in_ready[0]=0 until source 2's EOP is accepted.
- Granted source's first beat has sop=0 → sop_err=1 and stays 1; the packet still completes and the grant is released on EOP.
- With AVST_ARB_STATS_EN: 5 packets on source 3 and stat_sel=3 → stat_pkts=5. With STAT_W=2, 5 packets → stat_pkts=3 (saturated).
